// File: rtl/register_formatter.sv
// Streams a register number as ASCII text ("r"/"R", decimal digits, optional delimiter)
// over a valid/ready character interface. Define REGISTER_FORMATTER_ZERO_PAD_EN to always emit two digits.
module register_formatter #(
    parameter int UPPERCASE_PREFIX = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
    input  logic [4:0] register_in,
    input  logic [1:0] delim_in,
    output logic       ready_out,
    output logic [7:0] char_out,
    output logic       char_valid_out,
    input  logic       char_ready_in,
    output logic       done_out
);

    typedef enum logic [2:0] {IDLE, PREFIX, TENS, ONES, DELIM, DONE} state_t;

`ifdef REGISTER_FORMATTER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    localparam logic [7:0] PREFIX_CHAR = (UPPERCASE_PREFIX != 0) ? 8'h52 : 8'h72;

    state_t     state;
    state_t     state_next;
    logic [1:0] delim_q;
    logic [1:0] tens_q;
    logic [3:0] ones_q;
    logic [1:0] tens_calc;
    logic [3:0] ones_calc;
    logic [7:0] char_next;

    always_comb begin
        tens_calc = 2'd0;
        ones_calc = 4'(register_in);
        if (register_in >= 5'd30) begin
            tens_calc = 2'd3;
            ones_calc = 4'(register_in - 5'd30);
        end else if (register_in >= 5'd20) begin
            tens_calc = 2'd2;
            ones_calc = 4'(register_in - 5'd20);
        end else if (register_in >= 5'd10) begin
            tens_calc = 2'd1;
            ones_calc = 4'(register_in - 5'd10);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = PREFIX;
            PREFIX:  if (char_ready_in) state_next = (ZERO_PAD || tens_q != 2'd0) ? TENS : ONES;
            TENS:    if (char_ready_in) state_next = ONES;
            ONES:    if (char_ready_in) state_next = (delim_q != 2'd0) ? DELIM : DONE;
            DELIM:   if (char_ready_in) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Character for the state being entered; captured digits are already stable by the time they are needed.
    always_comb begin
        char_next = 8'h00;
        case (state_next)
            PREFIX: char_next = PREFIX_CHAR;
            TENS:   char_next = 8'h30 + {6'b0, tens_q};
            ONES:   char_next = 8'h30 + {4'b0, ones_q};
            DELIM: begin
                case (delim_q)
                    2'd1:    char_next = 8'h20;
                    2'd2:    char_next = 8'h2C;
                    2'd3:    char_next = 8'h0A;
                    default: char_next = 8'h00;
                endcase
            end
            default: char_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ready_out      <= 1'b1;
            char_valid_out <= 1'b0;
            char_out       <= '0;
            done_out       <= 1'b0;
            delim_q        <= '0;
            tens_q         <= '0;
            ones_q         <= '0;
        end else begin
            state          <= state_next;
            ready_out      <= (state_next == IDLE);
            char_valid_out <= (state_next == PREFIX) || (state_next == TENS) ||
                              (state_next == ONES) || (state_next == DELIM);
            char_out       <= char_next;
            done_out       <= (state_next == DONE);
            if (state == IDLE && start_in) begin
                delim_q <= delim_in;
                tens_q  <= tens_calc;
                ones_q  <= ones_calc;
            end
        end
    end

endmodule
